// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and the legality check used by the pipelined wrapper.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam int ALU_NUM_OPS = 10;

  // The opcode field is wider than the defined set, so raw encodings above ALU_SLTU can arrive.
  function automatic logic is_legal_op(alu_op_t op);
    return int'(op) < ALU_NUM_OPS;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic, shifts and compares with zero/negative/overflow flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             overflow_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign shamt   = b_i[SHW-1:0];
  assign sum     = a_i + b_i;
  assign diff    = a_i - b_i;
  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD:  begin result_o = sum;  overflow_o = add_ovf; end
      ALU_SUB:  begin result_o = diff; overflow_o = sub_ovf; end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_SLT:  result_o = WIDTH'($signed(a_i) < $signed(b_i));
      ALU_SLTU: result_o = WIDTH'(a_i < b_i);
      default:  result_o = '0;
    endcase
  end

  assign zero_o     = (result_o == '0);
  assign negative_o = result_o[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipeline around alu: stage 1 registers operands, stage 2 registers
// result, flags and tag. Full backpressure; op_count tallies completed output transfers.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TAG_WIDTH   = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in0,
  input  logic [WIDTH-1:0]       in1,
  input  alu_op_t                opcode,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   zero,
  output logic                   negative,
  output logic                   overflow,
  output logic                   illegal,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [COUNT_WIDTH-1:0] op_count
);

  logic                   s1_valid_q;
  logic [WIDTH-1:0]       s1_a_q;
  logic [WIDTH-1:0]       s1_b_q;
  alu_op_t                s1_op_q;
  logic [TAG_WIDTH-1:0]   s1_tag_q;

  logic                   s2_valid_q;
  logic [WIDTH-1:0]       result_q,   result_d;
  logic                   zero_q,     zero_d;
  logic                   negative_q, negative_d;
  logic                   overflow_q, overflow_d;
  logic                   illegal_q,  illegal_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic [WIDTH-1:0]       alu_result;
  logic                   alu_zero;
  logic                   alu_negative;
  logic                   alu_overflow;
  logic                   s1_en;
  logic                   s2_en;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .op_i       (s1_op_q),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .negative_o (alu_negative),
    .overflow_o (alu_overflow)
  );

  // Out-of-range opcodes bypass the alu and report a fixed all-clear result.
  always_comb begin
    result_d   = alu_result;
    zero_d     = alu_zero;
    negative_d = alu_negative;
    overflow_d = alu_overflow;
    illegal_d  = 1'b0;
    if (!is_legal_op(s1_op_q)) begin
      result_d   = '0;
      zero_d     = 1'b1;
      negative_d = 1'b0;
      overflow_d = 1'b0;
      illegal_d  = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so all stages sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= ALU_ADD;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      tag_q      <= '0;
      count_q    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q   <= in0;
          s1_b_q   <= in1;
          s1_op_q  <= opcode;
          s1_tag_q <= in_tag;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q   <= result_d;
          zero_q     <= zero_d;
          negative_q <= negative_d;
          overflow_q <= overflow_d;
          illegal_q  <= illegal_d;
          tag_q      <= s1_tag_q;
        end
      end
      if (s2_valid_q && out_ready) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign out_tag   = tag_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized valid/ready traffic
// compared every cycle against an in-order scoreboard of arithmetically computed responses.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in0;
  logic [W-1:0]  in1;
  alu_op_t       opcode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          negative;
  logic          overflow;
  logic          illegal;
  logic [TW-1:0] out_tag;
  logic [CW-1:0] op_count;

  alu_pipe #(.WIDTH(W), .TAG_WIDTH(TW), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .opcode    (opcode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .illegal   (illegal),
    .out_tag   (out_tag),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  result;
    logic          zero;
    logic          negative;
    logic          overflow;
    logic          illegal;
    logic [TW-1:0] tag;
  } resp_t;

  int            total = 0;
  int            bad   = 0;
  resp_t         exp_q[$];
  logic [CW-1:0] model_count;
  logic          mon_hold;
  resp_t         mon_held;
  resp_t         mon_cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference behaviour from plain signed/unsigned arithmetic on the operands.
  function automatic resp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] op, input logic [TW-1:0] tag);
    resp_t  r;
    longint sa;
    longint sb;
    longint s;
    longint smax;
    longint smin;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    r     = '0;
    r.tag = tag;
    case (op)
      4'd0: begin s = sa + sb; r.result = W'(s); r.overflow = (s > smax) || (s < smin); end
      4'd1: begin s = sa - sb; r.result = W'(s); r.overflow = (s > smax) || (s < smin); end
      4'd2: r.result = a & b;
      4'd3: r.result = a | b;
      4'd4: r.result = a ^ b;
      4'd5: r.result = a << b[4:0];
      4'd6: r.result = a >> b[4:0];
      4'd7: r.result = $signed(a) >>> b[4:0];
      4'd8: r.result = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r.result = (a < b) ? 32'd1 : 32'd0;
      default: begin r.result = '0; r.illegal = 1'b1; end
    endcase
    r.zero     = (r.result == '0);
    r.negative = r.result[W-1];
    return r;
  endfunction

  // Per-cycle compare against the scoreboard; transfers are decided by values held across the edge.
  initial begin
    mon_hold    = 1'b0;
    mon_held    = '0;
    model_count = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_count = '0;
        mon_hold    = 1'b0;
      end else begin
        mon_cur = {result, zero, negative, overflow, illegal, out_tag};
        if (mon_hold) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_stable", 64'(mon_cur), 64'(mon_held));
        end
        check("op_count", 64'(op_count), 64'(model_count));
        check("in_ready", 64'(in_ready), 64'((exp_q.size() >= 2 && !out_ready) ? 0 : 1));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_resp", 64'(out_valid), 64'd0);
          end else begin
            check("resp", 64'(mon_cur), 64'(exp_q[0]));
            if (out_ready) begin
              void'(exp_q.pop_front());
              model_count++;
            end
          end
        end
        mon_hold = out_valid && !out_ready;
        mon_held = mon_cur;
        if (in_valid && in_ready) exp_q.push_back(model(in0, in1, opcode, in_tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] a_tab [10];
  logic [W-1:0] b_tab [10];
  resp_t        got   [10];
  resp_t        r;
  logic         acc;
  int           sent;
  int           cyc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in0       = '0;
    in1       = '0;
    opcode    = ALU_ADD;
    in_tag    = '0;
    out_ready = 1'b1;

    // Hand-computed pins on the reference model.
    r = model(32'h7FFFFFFF, 32'd1, 4'd0, 4'd3);
    check("pin_add", 64'(r), 64'({32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3}));
    r = model(32'd5, 32'd5, 4'd1, 4'd0);
    check("pin_sub", 64'(r), 64'({32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
    r = model(32'h80000000, 32'd4, 4'd7, 4'd0);
    check("pin_sra", 64'(r.result), 64'(32'hF8000000));
    r = model(32'hFFFFFFFF, 32'd1, 4'd8, 4'd0);
    check("pin_slt", 64'(r.result), 64'd1);
    r = model(32'hFFFFFFFF, 32'd1, 4'd9, 4'd0);
    check("pin_sltu", 64'(r.result), 64'd0);
    r = model(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 4'd0);
    check("pin_illegal", 64'(r), 64'({32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0}));

    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);

    // Single ADD: latency and overflow flags.
    in_valid = 1'b1; in0 = 32'h7FFFFFFF; in1 = 32'd1; opcode = ALU_ADD; in_tag = 4'd3;
    step();
    in_valid = 1'b0;
    check("lat_not_yet", 64'(out_valid), 64'd0);
    step();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'(32'h80000000));
    check("add_flags", 64'({zero, negative, overflow}), 64'(3'b011));
    check("add_tag", 64'(out_tag), 64'd3);
    step();
    check("add_count", 64'(op_count), 64'd1);
    check("add_drained", 64'(out_valid), 64'd0);

    // Back-to-back streaming, one request per opcode.
    a_tab = '{32'd10, 32'd5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h80000000, 32'h80000000,
              32'hFFFFFFFF, 32'hFFFFFFFF};
    b_tab = '{32'd20, 32'd5, 32'hFF00, 32'hFF00, 32'hFF00, 32'd31, 32'd4, 32'd4, 32'd1, 32'd1};
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) begin
        in_valid = 1'b1; in0 = a_tab[c]; in1 = b_tab[c]; opcode = alu_op_t'(4'(c)); in_tag = 4'(c);
        check("stream_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        got[c-1] = {result, zero, negative, overflow, illegal, out_tag};
      end
    end
    check("stream_sub_zero", 64'(got[1].zero), 64'd1);
    check("stream_sra", 64'(got[7].result), 64'(32'hF8000000));
    check("stream_slt", 64'(got[8].result), 64'd1);
    check("stream_sltu", 64'(got[9].result), 64'd0);
    check("stream_tag", 64'(got[9].tag), 64'd9);
    step();

    // Backpressure: stall the consumer while the producer keeps offering.
    out_ready = 1'b0;
    in_tag    = 4'd0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in0 = 32'(c * 3); in1 = 32'd100; opcode = ALU_SUB;
      check("bp_in_ready", 64'(in_ready), 64'(c < 2));
      acc = in_ready;
      step();
      if (acc) in_tag = in_tag + 4'd1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Illegal opcode passes through with a fixed response.
    in_valid = 1'b1; in0 = 32'hFFFFFFFF; in1 = 32'hFFFFFFFF; opcode = alu_op_t'(4'd12); in_tag = 4'd9;
    step();
    in_valid = 1'b0;
    step();
    check("ill_valid", 64'(out_valid), 64'd1);
    check("ill_result", 64'(result), 64'd0);
    check("ill_flags", 64'({zero, negative, overflow, illegal}), 64'(4'b1001));
    step();

    // Randomized traffic with random valid/ready.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        case ($urandom_range(0, 4))
          0:       in0 = 32'h7FFFFFFF;
          1:       in0 = 32'h80000000;
          2:       in0 = 32'hFFFFFFFF;
          default: in0 = $urandom;
        endcase
        in1    = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
        opcode = alu_op_t'(4'($urandom_range(0, 11)));
        in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'd1000);
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    // Reset with both stages occupied discards everything in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in0 = 32'd1; in1 = 32'd2; opcode = ALU_ADD; in_tag = 4'd1;
    step();
    in_tag = 4'd2;
    step();
    in_tag = 4'd3;
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    check("rst2_op_count", 64'(op_count), 64'd0);
    out_ready = 1'b1;
    repeat (5) step();
    check("rst2_no_stale", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Pipelined, flow-controlled responder wrapped around the existing combinational alu. Accepts operation requests (in0, in1, opcode, tag) on a valid/ready input channel. Returns result, flags and tag on a valid/ready output channel.
- Two-stage pipeline with full backpressure support.
- Sits between an issue/sequencer block and writeback, replacing direct combinational ALU hookup where timing closure requires registered operands and results.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
TAG_WIDTH, 4, width of the opaque request tag returned with each response
COUNT_WIDTH, 16, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  pipeline can accept a request this cycle
in0  input  WIDTH  operand 0
in1  input  WIDTH  operand 1
opcode  input  alu_op_t  operation (alu_pkg)
in_tag  input  TAG_WIDTH  request tag
out_valid  output  1  response present
out_ready  input  1  consumer accepts response this cycle
result  output  WIDTH  operation result
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
overflow  output  1  signed overflow; ADD/SUB only, else 0
illegal  output  1  opcode outside defined alu_op_t range
out_tag  output  TAG_WIDTH  tag of the request this response belongs to
op_count  output  COUNT_WIDTH  number of completed output transfers

Behaviour:
Reset (rst=1 at a clock edge):
- s1_valid, s2_valid cleared; out_valid=0.
- result, flags, out_tag = 0; op_count = 0.
- in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight requests; no response is produced for them.

Transfers:
- Input transfer occurs on a cycle with in_valid && in_ready.
- Output transfer occurs on a cycle with out_valid && out_ready.

Stage 1:
- Registers in0, in1, opcode and tag on an input transfer.
- Holds its contents when it cannot advance.

Stage 2:
- Registers the alu sub-module outputs computed from the stage-1 operands, plus the tag and illegal bit.
- Drives all out_* ports directly from registers.

Enables:
- s2_en = !s2_valid || out_ready
- s1_en = !s1_valid || s2_en
- in_ready = s1_en (combinational; no in_valid dependence)

Latency and throughput:
- Request accepted at edge N appears with out_valid=1 after edge N+1, provided out_ready was high.
- Throughput is 1 op/cycle with out_ready held high.

Backpressure:
- While out_valid && !out_ready, all out_* ports stay stable.
- Stage 2 holds. Stage 1 fills if empty, then in_ready drops.
- No request is ever dropped or duplicated.
- Simultaneous output transfer and input transfer in the same cycle is legal; the pipeline advances by one.

Arithmetic (in0 as a, in1 as b):
- ADD/SUB: modulo 2^WIDTH.
  - ADD overflow = sign(a)==sign(b) && sign(res)!=sign(a).
  - SUB overflow = sign(a)!=sign(b) && sign(res)!=sign(a).
- AND/OR/XOR: bitwise.
- SLL/SRL/SRA: shift amount = in1[$clog2(WIDTH)-1:0].
- SLT/SLTU: result is 0 or 1, zero-extended.

Flags:
- zero and negative are computed from result for every opcode.
- overflow is forced to 0 for all opcodes except ADD/SUB.

Illegal opcode (numeric value >= 10):
- result=0, zero=1, negative=0, overflow=0, illegal=1.
- Flows through the pipeline like any other request.

op_count:
- Increments by 1 on each output transfer.
- Wraps from 2^COUNT_WIDTH-1 to 0.

Decomposition:
- alu_pkg (existing): alu_op_t enum (ALU_ADD..ALU_SLTU, values 0..9).
- alu_pkg additions: constant ALU_NUM_OPS = 10 and a function is_legal_op(alu_op_t).
- Sub-module: one instance of the existing alu (WIDTH passed through) between stage 1 and stage 2.
- Pipeline control and the illegal-opcode override live in alu_pipe.

Test Plan:
1. Reset, then ADD in0=32'h7FFFFFFF in1=1 tag=3 with out_ready=1 -> two edges later: result=32'h80000000, overflow=1, negative=1, zero=0, out_tag=3; op_count=1.
2. Streaming: 10 back-to-back requests, one per opcode, out_ready=1 -> in_ready stays 1; responses arrive in order, one per cycle.
   - SUB 5-5 -> zero=1.
   - SRA 32'h80000000 by 4 -> 32'hF8000000.
   - SLT -1<1 -> 1.
   - SLTU 32'hFFFFFFFF<1 -> 0.
3. Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts; out_* stay stable. Release out_ready -> all accepted requests emerge in order; no loss, no duplicates.
4. Random valid/ready toggling, 1000 requests with random operands and tags -> every response matches the scoreboard model; tags returned in order.
5. Illegal opcode 4'd12 with in0=in1=32'hFFFFFFFF -> result=0, zero=1, illegal=1, overflow=0.
6. Assert rst with both stages full -> the next cycle has out_valid=0, in_ready=1, op_count=0. No stale response appears afterwards.
